// File: rtl/fuzzy_mmio_bank.sv
`default_nettype none
// ============================================================================
// fuzzy_mmio_bank : MMIO bank with double-buffered fuzzy membership params,
//                   input snapshot on start, status tracking and level IRQ.
// Revision        : 1.0
// ============================================================================
module fuzzy_mmio_bank #(
  parameter int DW     = 8,
  parameter int N_IN   = 2,
  parameter int N_SET  = 3,
  parameter int ADDR_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cs,
  input  logic                      rd,
  input  logic                      wr,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DW-1:0]             wdata,
  output logic [DW-1:0]             rdata,
  output logic                      irq,
  output logic                      start,
  output logic                      init,
  output logic                      reg_mode,
  output logic                      dt_mode,
  output logic [N_IN*DW-1:0]        x_in,
  output logic [N_IN*N_SET*4*DW-1:0] mf_param,
  input  logic                      valid,
  input  logic [DW-1:0]             g_out
);

  localparam int NP = N_IN * N_SET * 4;
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_IRQ_EN = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_RESULT = ADDR_W'(3);

  logic [DW-1:0] shadow_x [N_IN];
  logic [DW-1:0] active_x [N_IN];
  logic [DW-1:0] shadow_p [NP];
  logic [DW-1:0] active_p [NP];
  logic [DW-1:0] result;
  logic [DW-1:0] rd_val;
  logic          irq_en;
  logic          busy;
  logic          done;
  logic          overrun;
  logic          pend;

  logic wr_en;
  logic rd_en;
  logic ctrl_wr;
  logic status_wr;
  logic commit_req;
  logic start_req;
  logic start_ok;
  logic load_active;
  logic unused_wdata;

  assign wr_en      = cs & wr;
  assign rd_en      = cs & rd & ~wr;
  assign ctrl_wr    = wr_en & (addr == A_CTRL);
  assign status_wr  = wr_en & (addr == A_STATUS);
  assign commit_req = ctrl_wr & wdata[7];
  assign start_req  = ctrl_wr & wdata[0];
  assign start_ok   = start_req & ~busy;
  // A commit while busy is deferred to the valid edge; a commit landing on the
  // valid edge itself is applied immediately rather than left pending.
  assign load_active = (commit_req & (~busy | valid)) | (valid & pend);
  assign unused_wdata = ^wdata;

  assign irq = done & irq_en;

  // ---------------------------------------------------------------- params
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NP; k++) begin
        shadow_p[k] <= '0;
        active_p[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NP; k++) begin
        if (wr_en && (addr == ADDR_W'(16 + k)))
          shadow_p[k] <= wdata;
        if (load_active)
          active_p[k] <= shadow_p[k];
      end
    end
  end

  // ---------------------------------------------------------------- inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) begin
        shadow_x[i] <= '0;
        active_x[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (wr_en && (addr == ADDR_W'(4 + i)))
          shadow_x[i] <= wdata;
        if (start_ok)
          active_x[i] <= shadow_x[i];
      end
    end
  end

  // ---------------------------------------------------------- control/status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init     <= 1'b0;
      reg_mode <= 1'b0;
      dt_mode  <= 1'b0;
      irq_en   <= 1'b0;
      start    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
      pend     <= 1'b0;
      result   <= '0;
    end else begin
      if (ctrl_wr) begin
        init     <= wdata[1];
        reg_mode <= wdata[2];
        dt_mode  <= wdata[3];
      end
      if (wr_en && (addr == A_IRQ_EN))
        irq_en <= wdata[0];

      start <= start_ok;

      // An accepted start outranks a simultaneous valid: a new job is running.
      if (start_ok)
        busy <= 1'b1;
      else if (valid)
        busy <= 1'b0;

      if (valid)
        done <= 1'b1;
      else if (status_wr && wdata[1])
        done <= 1'b0;

      if (start_req && busy)
        overrun <= 1'b1;
      else if (status_wr && wdata[2])
        overrun <= 1'b0;

      if (valid)
        pend <= 1'b0;
      else if (commit_req && busy)
        pend <= 1'b1;

      if (valid)
        result <= g_out;
    end
  end

  // ---------------------------------------------------------------- read path
  always_comb begin
    rd_val = '0;
    if (addr == A_CTRL) begin
      rd_val[3:1] = {dt_mode, reg_mode, init};
    end else if (addr == A_STATUS) begin
      rd_val[3:0] = {pend, overrun, done, busy};
    end else if (addr == A_IRQ_EN) begin
      rd_val[0] = irq_en;
    end else if (addr == A_RESULT) begin
      rd_val = result;
    end else begin
      for (int i = 0; i < N_IN; i++)
        if (addr == ADDR_W'(4 + i))
          rd_val = shadow_x[i];
      for (int k = 0; k < NP; k++)
        if (addr == ADDR_W'(16 + k))
          rd_val = shadow_p[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rdata <= '0;
    else if (rd_en)
      rdata <= rd_val;
  end

  // ---------------------------------------------------------------- packing
  generate
    for (genvar i = 0; i < N_IN; i++) begin : g_x_pack
      assign x_in[i*DW +: DW] = active_x[i];
    end
    for (genvar k = 0; k < NP; k++) begin : g_p_pack
      assign mf_param[k*DW +: DW] = active_p[k];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fuzzy_mmio_bank.sv
`default_nettype none
// ============================================================================
// tb_fuzzy_mmio_bank : directed self-checking bench for fuzzy_mmio_bank.
// Revision           : 1.0
// ============================================================================
module tb_fuzzy_mmio_bank;

  localparam int DW = 8, N_IN = 2, N_SET = 3, ADDR_W = 8;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic                          cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [ADDR_W-1:0]             addr = '0;
  logic [DW-1:0]                 wdata = '0;
  logic [DW-1:0]                 rdata;
  logic                          irq, start, init, reg_mode, dt_mode;
  logic [N_IN*DW-1:0]            x_in;
  logic [N_IN*N_SET*4*DW-1:0]    mf_param;
  logic                          valid = 1'b0;
  logic [DW-1:0]                 g_out = '0;

  int pass_cnt = 0;
  int total_cnt = 0;

  fuzzy_mmio_bank #(.DW(DW), .N_IN(N_IN), .N_SET(N_SET), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .rd(rd), .wr(wr), .addr(addr),
    .wdata(wdata), .rdata(rdata), .irq(irq), .start(start), .init(init),
    .reg_mode(reg_mode), .dt_mode(dt_mode), .x_in(x_in), .mf_param(mf_param),
    .valid(valid), .g_out(g_out)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled on falling edges.
  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk); cs = 1; wr = 1; addr = a; wdata = d;
    @(negedge clk); cs = 0; wr = 0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk); cs = 1; rd = 1; addr = a;
    @(negedge clk); cs = 0; rd = 0;
    d = rdata;
  endtask

  task automatic pulse_valid(input logic [7:0] g);
    @(negedge clk); valid = 1; g_out = g;
    @(negedge clk); valid = 0;
  endtask

  task automatic write_with_valid(input logic [7:0] a, input logic [7:0] d, input logic [7:0] g);
    @(negedge clk); cs = 1; wr = 1; addr = a; wdata = d; valid = 1; g_out = g;
    @(negedge clk); cs = 0; wr = 0; valid = 0;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    rst_n = 0;
    repeat (3) @(negedge clk);
    total_cnt++; if (rdata !== 8'h00) $display("FAIL reset_rdata got %h want 00", rdata); else pass_cnt++;
    total_cnt++; if (irq !== 1'b0) $display("FAIL reset_irq got %b want 0", irq); else pass_cnt++;
    total_cnt++; if (start !== 1'b0) $display("FAIL reset_start got %b want 0", start); else pass_cnt++;
    total_cnt++; if (x_in !== '0) $display("FAIL reset_x_in got %h want 0", x_in); else pass_cnt++;
    total_cnt++; if (mf_param !== '0) $display("FAIL reset_mf_param got %h want 0", mf_param); else pass_cnt++;
    rst_n = 1;
    bus_read(8'h01, d);
    total_cnt++; if (d !== 8'h00) $display("FAIL reset_status got %h want 00", d); else pass_cnt++;
  endtask

  task automatic test_commit;
    logic [7:0] d;
    bus_write(8'h10, 8'hE0);
    bus_read(8'h10, d);
    total_cnt++; if (d !== 8'hE0) $display("FAIL shadow_read got %h want e0", d); else pass_cnt++;
    total_cnt++; if (mf_param[7:0] !== 8'h00) $display("FAIL active_before_commit got %h want 00", mf_param[7:0]); else pass_cnt++;
    bus_write(8'h00, 8'h80);
    total_cnt++; if (mf_param[7:0] !== 8'hE0) $display("FAIL active_after_commit got %h want e0", mf_param[7:0]); else pass_cnt++;
    bus_read(8'h00, d);
    total_cnt++; if (d !== 8'h00) $display("FAIL ctrl_commit_readback got %h want 00", d); else pass_cnt++;
  endtask

  task automatic test_ctrl_bits;
    logic [7:0] d;
    bus_write(8'h00, 8'h0E);
    total_cnt++; if ({dt_mode, reg_mode, init} !== 3'b111) $display("FAIL ctrl_levels got %b want 111", {dt_mode, reg_mode, init}); else pass_cnt++;
    total_cnt++; if (start !== 1'b0) $display("FAIL ctrl_no_start got %b want 0", start); else pass_cnt++;
    bus_read(8'h00, d);
    total_cnt++; if (d !== 8'h0E) $display("FAIL ctrl_readback got %h want 0e", d); else pass_cnt++;
    bus_write(8'h00, 8'h04);
    total_cnt++; if ({dt_mode, reg_mode, init} !== 3'b010) $display("FAIL ctrl_levels2 got %b want 010", {dt_mode, reg_mode, init}); else pass_cnt++;
    bus_write(8'h00, 8'h00);
  endtask

  task automatic test_start;
    logic [7:0] d;
    bus_write(8'h04, 8'h19);
    bus_write(8'h05, 8'hFB);
    total_cnt++; if (x_in !== 16'h0000) $display("FAIL x_in_before_start got %h want 0000", x_in); else pass_cnt++;
    bus_write(8'h00, 8'h01);
    total_cnt++; if (start !== 1'b1) $display("FAIL start_pulse_high got %b want 1", start); else pass_cnt++;
    total_cnt++; if (x_in !== 16'hFB19) $display("FAIL x_in_snapshot got %h want fb19", x_in); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (start !== 1'b0) $display("FAIL start_pulse_low got %b want 0", start); else pass_cnt++;
    bus_read(8'h01, d);
    total_cnt++; if (d !== 8'h01) $display("FAIL status_busy got %h want 01", d); else pass_cnt++;
    pulse_valid(8'h5A);
    bus_read(8'h01, d);
    total_cnt++; if (d !== 8'h02) $display("FAIL status_done got %h want 02", d); else pass_cnt++;
    bus_read(8'h03, d);
    total_cnt++; if (d !== 8'h5A) $display("FAIL result got %h want 5a", d); else pass_cnt++;
  endtask

  task automatic test_irq;
    bus_write(8'h01, 8'h02);
    bus_write(8'h02, 8'h01);
    total_cnt++; if (irq !== 1'b0) $display("FAIL irq_idle got %b want 0", irq); else pass_cnt++;
    bus_write(8'h00, 8'h01);
    pulse_valid(8'h10);
    total_cnt++; if (irq !== 1'b1) $display("FAIL irq_after_valid got %b want 1", irq); else pass_cnt++;
    bus_write(8'h01, 8'h02);
    total_cnt++; if (irq !== 1'b0) $display("FAIL irq_cleared got %b want 0", irq); else pass_cnt++;
  endtask

  task automatic test_busy_commit;
    logic [7:0] d;
    bus_write(8'h00, 8'h01);
    bus_write(8'h00, 8'h81);
    total_cnt++; if (start !== 1'b0) $display("FAIL busy_start_rejected got %b want 0", start); else pass_cnt++;
    bus_read(8'h01, d);
    total_cnt++; if (d !== 8'h0D) $display("FAIL status_pending got %h want 0d", d); else pass_cnt++;
    bus_write(8'h11, 8'h7F);
    total_cnt++; if (mf_param[15:8] !== 8'h00) $display("FAIL pending_not_applied got %h want 00", mf_param[15:8]); else pass_cnt++;
    pulse_valid(8'h44);
    total_cnt++; if (mf_param[15:8] !== 8'h7F) $display("FAIL pending_applied got %h want 7f", mf_param[15:8]); else pass_cnt++;
    total_cnt++; if (mf_param[7:0] !== 8'hE0) $display("FAIL param0_kept got %h want e0", mf_param[7:0]); else pass_cnt++;
    bus_read(8'h01, d);
    total_cnt++; if (d !== 8'h06) $display("FAIL status_after_pending got %h want 06", d); else pass_cnt++;
  endtask

  task automatic test_simultaneous;
    logic [7:0] d;
    bus_write(8'h01, 8'h06);
    bus_write(8'h00, 8'h01);
    write_with_valid(8'h00, 8'h01, 8'h21);
    total_cnt++; if (start !== 1'b0) $display("FAIL start_on_valid_rejected got %b want 0", start); else pass_cnt++;
    bus_read(8'h01, d);
    total_cnt++; if (d !== 8'h06) $display("FAIL status_start_on_valid got %h want 06", d); else pass_cnt++;
    bus_write(8'h01, 8'h06);
    bus_write(8'h00, 8'h01);
    write_with_valid(8'h01, 8'h02, 8'h22);
    bus_read(8'h01, d);
    total_cnt++; if (d !== 8'h02) $display("FAIL done_set_wins got %h want 02", d); else pass_cnt++;
    bus_read(8'h03, d);
    total_cnt++; if (d !== 8'h22) $display("FAIL result_simul got %h want 22", d); else pass_cnt++;
  endtask

  task automatic test_bus_edges;
    logic [7:0] d;
    bus_read(8'h03, d);
    @(negedge clk); cs = 1; rd = 1; wr = 1; addr = 8'h12; wdata = 8'h55;
    @(negedge clk); cs = 0; rd = 0; wr = 0;
    total_cnt++; if (rdata !== 8'h22) $display("FAIL rd_wr_rdata_hold got %h want 22", rdata); else pass_cnt++;
    bus_read(8'h12, d);
    total_cnt++; if (d !== 8'h55) $display("FAIL rd_wr_write_wins got %h want 55", d); else pass_cnt++;
    bus_read(8'h0F, d);
    total_cnt++; if (d !== 8'h00) $display("FAIL unmapped_read got %h want 00", d); else pass_cnt++;
    bus_write(8'h03, 8'h99);
    bus_read(8'h03, d);
    total_cnt++; if (d !== 8'h22) $display("FAIL result_readonly got %h want 22", d); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    bus_write(8'h00, 8'h01);
    total_cnt++; if (irq !== 1'b1) $display("FAIL irq_before_reset got %b want 1", irq); else pass_cnt++;
    @(negedge clk); rst_n = 0;
    #1;
    total_cnt++; if (irq !== 1'b0) $display("FAIL mid_reset_irq got %b want 0", irq); else pass_cnt++;
    total_cnt++; if (mf_param !== '0) $display("FAIL mid_reset_params got %h want 0", mf_param); else pass_cnt++;
    total_cnt++; if (x_in !== '0) $display("FAIL mid_reset_x_in got %h want 0", x_in); else pass_cnt++;
    @(negedge clk); rst_n = 1;
    bus_read(8'h01, d);
    total_cnt++; if (d !== 8'h00) $display("FAIL mid_reset_status got %h want 00", d); else pass_cnt++;
    pulse_valid(8'h33);
    bus_read(8'h03, d);
    total_cnt++; if (d !== 8'h33) $display("FAIL late_valid_result got %h want 33", d); else pass_cnt++;
    bus_read(8'h01, d);
    total_cnt++; if (d !== 8'h02) $display("FAIL late_valid_done got %h want 02", d); else pass_cnt++;
    total_cnt++; if (irq !== 1'b0) $display("FAIL late_valid_irq got %b want 0", irq); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_commit();
    test_ctrl_bits();
    test_start();
    test_irq();
    test_busy_commit();
    test_simultaneous();
    test_bus_edges();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fuzzy_mmio_bank.md
Name: fuzzy_mmio_bank

Overview:
Parametrised MMIO register bank sitting between the MCU 8-bit-style bus and the fuzzy coprocessor core. It generalises the earlier shadow interface to N_IN crisp inputs, each with N_SET trapezoid sets of 4 points (a,b,c,d), and to DW-bit data. New behaviour over the earlier interface:
- shadow/active double-buffered membership parameters with a commit handshake;
- input snapshot at start;
- busy/done/overrun status tracking;
- registered read path;
- level interrupt.

Parameters:
DW, 8, data/parameter width (bus data width equals DW)
N_IN, 2, number of crisp inputs (index 0 = T, 1 = dT)
N_SET, 3, fuzzy sets per input (0=neg, 1=zero, 2=pos)
ADDR_W, 8, bus address width; requires 16 + N_IN*N_SET*4 <= 2**ADDR_W

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cs  in  1  bus chip select
rd  in  1  bus read strobe
wr  in  1  bus write strobe
addr  in  ADDR_W  bus address
wdata  in  DW  bus write data
rdata  out  DW  bus read data, registered
irq  out  1  level interrupt = done & irq_en
start  out  1  one-cycle start pulse to core
init  out  1  init level to core (CTRL bit1)
reg_mode  out  1  CTRL bit2
dt_mode  out  1  CTRL bit3
x_in  out  N_IN*DW  active input snapshot, signed, input i at [i*DW +: DW]
mf_param  out  N_IN*N_SET*4*DW  active parameters, signed, index ((i*N_SET+s)*4+p)
valid  in  1  core result strobe (one cycle)
g_out  in  DW  core result

Behaviour:
- Reset: all registers (shadow, active, CTRL, IRQ_EN, STATUS, RESULT, rdata, start) are 0, so irq=0.
- Address map:
  - 0x00 CTRL. Write: bit0 start (self-clearing), bit1 init, bit2 reg_mode, bit3 dt_mode, bit7 commit (self-clearing). Read returns bits 3:1; bits 0 and 7 read 0.
  - 0x01 STATUS. Read: bit0 busy, bit1 done, bit2 overrun, bit3 commit_pending. Writing 1 to bit1 or bit2 clears that bit.
  - 0x02 IRQ_EN, bit0 only.
  - 0x03 RESULT, read-only.
  - 0x04+i: input shadow i, for i < N_IN.
  - 0x10+k: parameter shadow k, for k < N_IN*N_SET*4.
  - Unmapped reads return 0. Unmapped and read-only writes are ignored.
- Write: when cs&wr are high, the write takes effect at the posedge. If rd&wr are both high, the write wins and rdata holds its previous value.
- Read: when cs&rd&!wr, rdata is loaded at the posedge and is valid on the following cycle (1-cycle latency). Otherwise rdata holds.
- Shadow registers always reflect the last write, regardless of busy.
- Commit, when CTRL is written with bit7=1:
  - if !busy: active params <= shadow at the same edge;
  - if busy: commit_pending is set, and active params <= shadow at the edge where valid is sampled; commit_pending then clears.
  - Pending commits do not stack; the latest shadow contents are used.
- Start, when CTRL is written with bit0=1:
  - if !busy: at the same edge x_in <= input shadows, start <= 1, busy <= 1. start drops after one cycle.
  - if busy: the request is rejected, overrun <= 1, and no pulse is issued.
- Commit and start in the same write: the params update happens at that same edge, so the core sees the new params when it samples start.
- When valid is sampled: RESULT <= g_out, busy <= 0, done <= 1.
  - valid while !busy is still captured and sets done.
- Simultaneous events:
  - start write at the same edge as valid: busy is still 1, so start is rejected with overrun.
  - done-clear write at the same edge as valid: set wins, done = 1.
- Reset asserted mid-operation returns everything to reset values immediately. A later valid from the core is handled as above.

Test Plan:
- Reset with rst_n=0 for 3 cycles -> rdata=0, irq=0, start=0, x_in=0, mf_param=0. A STATUS read returns 0x00.
- Write 0x10=0xE0, read 0x10 -> rdata=0xE0 one cycle after rd, and mf_param[7:0] is still 0. Then write CTRL=0x80 -> mf_param[7:0]=0xE0 next cycle.
- Write 0x04=0x19, 0x05=0xFB, CTRL=0x01 -> start high exactly 1 cycle, x_in={0xFB,0x19}, STATUS=0x01. Drive valid with g_out=0x5A -> STATUS=0x02, RESULT reads 0x5A.
- Set IRQ_EN=1, run the start/valid sequence -> irq=1 after valid. Write STATUS=0x02 -> irq=0 next cycle.
- While busy: write CTRL=0x81 -> no start pulse, STATUS=0x0D (busy|overrun|commit_pending). Change 0x11 to 0x7F, then valid -> mf_param[15:8]=0x7F, STATUS=0x06.
- Assert rst_n=0 while busy -> busy=0, active params=0, irq=0. Then valid with g_out=0x33 -> RESULT=0x33, done=1.
